// File: rtl/kmp_fail_gen_if.sv
// Request/result bundle for the KMP failure-table generator.
// Optional KMP_FF_CYCLE_CNT_EN adds the build_cycles observation port.
interface kmp_fail_gen_if #(
    parameter int MAX_PATTERN = 8,
    parameter int PAT_ADD     = 3,
    parameter int BYTE        = 8
);
    logic [MAX_PATTERN*BYTE-1:0]    pat_input;
    logic [PAT_ADD-1:0]             pat_last_idx;
    logic                           input_valid;
    logic [PAT_ADD*MAX_PATTERN-1:0] ff_result;
    logic                           output_valid;
    logic                           busy;
`ifdef KMP_FF_CYCLE_CNT_EN
    logic [PAT_ADD+1:0]             build_cycles;

    modport master (
        output pat_input, pat_last_idx, input_valid,
        input  ff_result, output_valid, busy, build_cycles
    );
    modport slave (
        input  pat_input, pat_last_idx, input_valid,
        output ff_result, output_valid, busy, build_cycles
    );
`else
    modport master (
        output pat_input, pat_last_idx, input_valid,
        input  ff_result, output_valid, busy
    );
    modport slave (
        input  pat_input, pat_last_idx, input_valid,
        output ff_result, output_valid, busy
    );
`endif
endinterface

// File: rtl/kmp_fail_gen.sv
// KMP failure-function table builder, one compare step per cycle.
// Define KMP_FF_CYCLE_CNT_EN to add the build_cycles counter output.
//
// state | meaning
// IDLE  | waiting for input_valid
// LOAD  | latch pattern and last index, clear table
// BUILD | one prefix/suffix compare step per cycle
// DONE  | table valid, held until input_valid drops
module kmp_fail_gen #(
    parameter int MAX_PATTERN = 8,
    parameter int PAT_ADD     = 3,
    parameter int BYTE        = 8
) (
    input  logic          clk,
    input  logic          reset,
    kmp_fail_gen_if.slave bus
);
    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_LOAD  = 4'b0010;
    localparam logic [3:0] S_BUILD = 4'b0100;
    localparam logic [3:0] S_DONE  = 4'b1000;

    localparam logic [PAT_ADD:0]   ONE_W = 1;
    localparam logic [PAT_ADD-1:0] ONE_N = 1;

    logic [3:0]         r_state;
    logic [PAT_ADD:0]   r_i;
    logic [PAT_ADD:0]   r_k;
    logic [PAT_ADD-1:0] r_last;
    logic               r_valid;
    logic [BYTE-1:0]    r_chars [MAX_PATTERN];
    logic [PAT_ADD-1:0] r_table [MAX_PATTERN];

    logic w_match;
    logic w_i_last;

    assign w_match  = (r_chars[r_i[PAT_ADD-1:0]] == r_chars[r_k[PAT_ADD-1:0]]);
    assign w_i_last = (r_i == {1'b0, r_last});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_k     <= '0;
            r_last  <= '0;
            r_valid <= 1'b0;
            for (int n = 0; n < MAX_PATTERN; n++) begin
                r_chars[n] <= '0;
                r_table[n] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.input_valid)
                        r_state <= S_LOAD;
                end
                S_LOAD, S_BUILD: begin
                    if (!bus.input_valid) begin
                        // Abort: a partial table must never be visible afterwards.
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_i     <= '0;
                        r_k     <= '0;
                        for (int n = 0; n < MAX_PATTERN; n++)
                            r_table[n] <= '0;
                    end else if (r_state == S_LOAD) begin
                        for (int n = 0; n < MAX_PATTERN; n++) begin
                            r_chars[n] <= bus.pat_input[n*BYTE +: BYTE];
                            r_table[n] <= '0;
                        end
                        r_last  <= bus.pat_last_idx;
                        r_i     <= ONE_W;
                        r_k     <= '0;
                        r_state <= S_BUILD;
                    end else if (r_last == '0) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                    end else if (w_match) begin
                        r_k                          <= r_k + ONE_W;
                        r_table[r_i[PAT_ADD-1:0]]    <= r_k[PAT_ADD-1:0] + ONE_N;
                        r_i                          <= r_i + ONE_W;
                        if (w_i_last) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b1;
                        end
                    end else if (r_k != '0) begin
                        r_k <= {1'b0, r_table[r_k[PAT_ADD-1:0] - ONE_N]};
                    end else begin
                        r_table[r_i[PAT_ADD-1:0]] <= '0;
                        r_i                       <= r_i + ONE_W;
                        if (w_i_last) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.input_valid) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.ff_result = '0;
        for (int n = 0; n < MAX_PATTERN; n++)
            bus.ff_result[n*PAT_ADD +: PAT_ADD] = r_table[n];
    end

    assign bus.output_valid = r_valid;
    assign bus.busy         = (r_state == S_LOAD) || (r_state == S_BUILD);

`ifdef KMP_FF_CYCLE_CNT_EN
    localparam logic [PAT_ADD+1:0] ONE_C = 1;
    logic [PAT_ADD+1:0] r_build_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_build_cycles <= '0;
        else if (r_state == S_LOAD)
            r_build_cycles <= '0;
        else if (r_state == S_BUILD)
            r_build_cycles <= r_build_cycles + ONE_C;
    end

    assign bus.build_cycles = r_build_cycles;
`endif
endmodule

// File: tb/tb_kmp_fail_gen.sv
// Directed bench for kmp_fail_gen: brute-force prefix/suffix model plus literal pins.
// Honours KMP_FF_CYCLE_CNT_EN when the design is built with it.
module tb_kmp_fail_gen;
    localparam int MP = 8;
    localparam int PA = 3;
    localparam int BY = 8;

    logic clk;
    logic reset;
    int   vec  = 0;
    int   miss = 0;
    logic [PA*MP-1:0] exp_ff;

    kmp_fail_gen_if #(.MAX_PATTERN(MP), .PAT_ADD(PA), .BYTE(BY)) bus ();
    kmp_fail_gen #(.MAX_PATTERN(MP), .PAT_ADD(PA), .BYTE(BY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vec++;
        if (act !== expv) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Longest proper prefix that is also a suffix, by exhaustive search.
    function automatic logic [PA*MP-1:0] model(input logic [MP*BY-1:0] p, input int last);
        logic [PA*MP-1:0] r;
        logic found, same;
        r = '0;
        for (int i = 1; i <= last; i++) begin
            found = 1'b0;
            for (int len = i; len >= 1; len--) begin
                if (!found) begin
                    same = 1'b1;
                    for (int j = 0; j < len; j++)
                        if (p[j*BY +: BY] != p[(i-len+1+j)*BY +: BY]) same = 1'b0;
                    if (same) begin
                        r[i*PA +: PA] = len[PA-1:0];
                        found = 1'b1;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [PA*MP-1:0] pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [PA*MP-1:0] r;
        int t [8];
        t = '{a0, a1, a2, a3, a4, a5, a6, a7};
        r = '0;
        for (int n = 0; n < 8; n++) r[n*PA +: PA] = t[n][PA-1:0];
        return r;
    endfunction

    function automatic logic [MP*BY-1:0] str2pat(input string s);
        logic [MP*BY-1:0] r;
        r = '0;
        for (int n = 0; n < MP; n++)
            r[n*BY +: BY] = (n < s.len()) ? s[n] : 8'($urandom_range(255));
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset && bus.output_valid)
            chk("ff_result_vs_model", 64'(bus.ff_result), 64'(exp_ff));
    end

    task automatic run_req(input string s, input int last, input int exp_lat,
                           input int exp_build, input logic [PA*MP-1:0] lit);
        int lat, busyc;
        bus.pat_input    = str2pat(s);
        bus.pat_last_idx = PA'(last);
        exp_ff           = model(bus.pat_input, last);
        chk({"model_pin_", s}, 64'(exp_ff), 64'(lit));
        bus.input_valid  = 1'b1;
        lat = 0;
        busyc = 0;
        while (!bus.output_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busyc++;
        end
        chk({"latency_", s}, 64'(lat), 64'(exp_lat));
        chk({"build_cycles_obs_", s}, 64'(busyc - 1), 64'(exp_build));
        chk({"build_bound_", s}, 64'((busyc - 1) <= ((last == 0) ? 1 : 2*last)), 64'(1));
`ifdef KMP_FF_CYCLE_CNT_EN
        chk({"build_cycles_port_", s}, 64'(bus.build_cycles), 64'(exp_build));
`endif
        repeat (2) @(negedge clk);
        bus.pat_input    = str2pat("ZZZZZZZZ");
        bus.pat_last_idx = PA'(MP - 1 - last);
        repeat (2) @(negedge clk);
        chk({"held_valid_", s}, 64'(bus.output_valid), 64'(1));
        bus.input_valid = 1'b0;
        @(negedge clk);
        chk({"valid_drop_", s}, 64'(bus.output_valid), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        int ov_seen;
        reset            = 1'b0;
        bus.input_valid  = 1'b0;
        bus.pat_input    = '0;
        bus.pat_last_idx = '0;
        exp_ff           = '0;
        repeat (3) @(negedge clk);
        chk("reset_ff", 64'(bus.ff_result), 64'(0));
        chk("reset_valid", 64'(bus.output_valid), 64'(0));
        chk("reset_busy", 64'(bus.busy), 64'(0));
        reset = 1'b1;

        run_req("AABAAA",   5, 9,  7, pack8(0,1,0,1,2,2,0,0));
        run_req("ABCD",     3, 5,  3, pack8(0,0,0,0,0,0,0,0));
        run_req("AAAAAAAA", 7, 9,  7, pack8(0,1,2,3,4,5,6,7));
        run_req("Q",        0, 3,  1, pack8(0,0,0,0,0,0,0,0));
        run_req("ABABCABA", 7, 10, 8, pack8(0,0,1,2,0,1,2,3));
        run_req("ABAB",     2, 4,  2, pack8(0,0,1,0,0,0,0,0));

        // Asynchronous reset in the third BUILD cycle.
        bus.pat_input    = str2pat("AABAAA");
        bus.pat_last_idx = 3'd5;
        bus.input_valid  = 1'b1;
        repeat (4) @(negedge clk);
        chk("partial_table_before_reset", 64'(bus.ff_result != '0), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk("async_reset_ff", 64'(bus.ff_result), 64'(0));
        chk("async_reset_busy", 64'(bus.busy), 64'(0));
        chk("async_reset_valid", 64'(bus.output_valid), 64'(0));
        bus.input_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_req("AABAAA", 5, 9, 7, pack8(0,1,0,1,2,2,0,0));

        // input_valid dropped mid-BUILD.
        bus.pat_input    = str2pat("AABAAA");
        bus.pat_last_idx = 3'd5;
        bus.input_valid  = 1'b1;
        repeat (4) @(negedge clk);
        bus.input_valid = 1'b0;
        ov_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.output_valid) ov_seen++;
        end
        chk("abort_valid_never", 64'(ov_seen), 64'(0));
        chk("abort_ff", 64'(bus.ff_result), 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        run_req("ABCD", 3, 5, 3, pack8(0,0,0,0,0,0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
